// File: rtl/pin_entry_controller.sv
// -----------------------------------------------------------------------------
// pin_entry_controller
//
// This controller sits on the keypad side of the door lock. It collects PIN
// digits from the debounced keypad scanner and compares the completed entry
// with a stored code. It then drives the lock FSM:
//   - A correct entry gives a one-cycle toggle_lock pulse.
//   - A wrong entry gives a one-cycle fail_pulse.
//   - MAX_FAILS consecutive wrong entries block the keypad. During the block,
//     override stays high for BLOCK_CYCLES cycles and the lock FSM ignores
//     keypad toggles.
//
// Ports (all synchronous to the rising edge of clk5):
//   clk5         system clock
//   reset        synchronous, active-high; overrides every other input
//   key_valid    one-cycle pulse per debounced keypress
//   key_code     0-9 digit, 4'hE clear, 4'hF enter, 4'hA-4'hD ignored
//   toggle_lock  one-cycle pulse: correct PIN accepted
//   override     high while the keypad is blocked
//   fail_pulse   one-cycle pulse: wrong PIN entered
//   digit_count  digits held in the entry buffer (saturates at DIGITS)
//   fail_count   consecutive failures since last success or block expiry
// -----------------------------------------------------------------------------
module pin_entry_controller #(
    parameter int                  DIGITS         = 4,
    parameter logic [4*DIGITS-1:0] PIN            = 16'h1234,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  BLOCK_CYCLES   = 50,
    parameter int                  TIMEOUT_CYCLES = 25
) (
    input  logic       clk5,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       toggle_lock,
    output logic       override,
    output logic       fail_pulse,
    output logic [2:0] digit_count,
    output logic [2:0] fail_count
);

    localparam int BUF_W = 4 * DIGITS;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BLK_W = $clog2(BLOCK_CYCLES + 1);

    localparam logic [2:0]       DIGITS_C  = 3'(DIGITS);
    localparam logic [2:0]       MAX_C     = 3'(MAX_FAILS);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buffer_q, buffer_d;
    logic               overflow_q, overflow_d;
    logic [TO_W-1:0]    idle_q, idle_d;
    logic [BLK_W-1:0]   block_q, block_d;
    logic [2:0]         digit_count_d, fail_count_d;
    logic               toggle_lock_d, fail_pulse_d, override_d;
    logic [2:0]         fail_next;

    logic is_digit, is_clear, is_enter;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_clear = key_valid && (key_code == 4'hE);
    assign is_enter = key_valid && (key_code == 4'hF);

    // Next-state and next-output logic. Every output comes from a flop, so
    // this block computes the value each register takes on the next edge.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        state_d       = state_q;
        buffer_d      = buffer_q;
        overflow_d    = overflow_q;
        idle_d        = idle_q;
        block_d       = block_q;
        digit_count_d = digit_count;
        fail_count_d  = fail_count;
        override_d    = override;
        toggle_lock_d = 1'b0;
        fail_pulse_d  = 1'b0;
        fail_next     = fail_count + 3'd1;

        case (state_q)
            IDLE: begin
                idle_d     = '0;
                block_d    = '0;
                override_d = 1'b0;
                // Clear and enter have no entry to act on here, so they are dropped.
                if (is_digit) begin
                    buffer_d      = BUF_W'(key_code);
                    digit_count_d = 3'd1;
                    overflow_d    = 1'b0;
                    state_d       = ENTRY;
                end
            end

            ENTRY: begin
                // Any key, ignored codes included, counts as keypad activity.
                idle_d = key_valid ? '0 : idle_q + 1'b1;

                if (is_digit) begin
                    buffer_d = (buffer_q << 4) | BUF_W'(key_code);
                    // A digit past a full buffer cannot match the PIN. Remember
                    // it so that enter fails even though the buffer looks full.
                    if (digit_count == DIGITS_C) overflow_d    = 1'b1;
                    else                         digit_count_d = digit_count + 3'd1;
                end else if (is_clear) begin
                    buffer_d      = '0;
                    digit_count_d = '0;
                    overflow_d    = 1'b0;
                    state_d       = IDLE;
                end else if (is_enter) begin
                    buffer_d      = '0;
                    digit_count_d = '0;
                    overflow_d    = 1'b0;
                    if (digit_count == DIGITS_C && !overflow_q && buffer_q == PIN) begin
                        toggle_lock_d = 1'b1;
                        fail_count_d  = '0;
                        state_d       = IDLE;
                    end else begin
                        fail_pulse_d = 1'b1;
                        fail_count_d = fail_next;
                        if (fail_next == MAX_C) begin
                            // override goes high in the same cycle as the
                            // final fail_pulse, so the lock FSM never sees a
                            // gap between them.
                            override_d = 1'b1;
                            block_d    = '0;
                            state_d    = BLOCKED;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (!key_valid && idle_q == TO_LAST) begin
                    // Abandoned partial entry: it is discarded without counting as a failure.
                    buffer_d      = '0;
                    digit_count_d = '0;
                    overflow_d    = 1'b0;
                    state_d       = IDLE;
                end
            end

            BLOCKED: begin
                // Keys are ignored and do not extend the block. The count
                // starts on the entry edge, so override is high for exactly
                // BLOCK_CYCLES cycles.
                if (block_q == BLK_LAST) begin
                    override_d   = 1'b0;
                    fail_count_d = '0;
                    block_d      = '0;
                    state_d      = IDLE;
                end else begin
                    block_d = block_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk5) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            // NOTE: the entry buffer is reset along with the control state so that no stale digits survive a reset.
            state_q     <= IDLE;
            buffer_q    <= '0;
            overflow_q  <= 1'b0;
            idle_q      <= '0;
            block_q     <= '0;
            digit_count <= '0;
            fail_count  <= '0;
            toggle_lock <= 1'b0;
            fail_pulse  <= 1'b0;
            override    <= 1'b0;
        end else begin
            state_q     <= state_d;
            buffer_q    <= buffer_d;
            overflow_q  <= overflow_d;
            idle_q      <= idle_d;
            block_q     <= block_d;
            digit_count <= digit_count_d;
            fail_count  <= fail_count_d;
            toggle_lock <= toggle_lock_d;
            fail_pulse  <= fail_pulse_d;
            override    <= override_d;
        end
    end

endmodule

// File: tb/tb_pin_entry_controller.sv
// -----------------------------------------------------------------------------
// tb_pin_entry_controller
//
// Self-checking bench for pin_entry_controller with its default parameters
// (PIN 1234, 3 fails, 50-cycle block, 25-cycle timeout).
//
// Each stimulus record drives one clock cycle. The record also carries the
// outputs expected right after that edge. Those expectations are pushed to a
// scoreboard queue when the stimulus is driven. They are popped and compared
// 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_pin_entry_controller;

    logic       clk5 = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       toggle_lock, override, fail_pulse;
    logic [2:0] digit_count, fail_count;

    pin_entry_controller dut (
        .clk5        (clk5),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .toggle_lock (toggle_lock),
        .override    (override),
        .fail_pulse  (fail_pulse),
        .digit_count (digit_count),
        .fail_count  (fail_count)
    );

    always #5 clk5 = ~clk5;

    typedef struct {
        logic       rst;
        logic       kv;
        logic [3:0] code;
        logic       tl, fp, ov;
        logic [2:0] dc, fc;
    } vec_t;

    typedef struct {
        int         idx;
        logic       tl, fp, ov;
        logic [2:0] dc, fc;
    } exp_t;

    vec_t table_q[$];
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int step     = 0;

    logic [3:0] good_pin [4] = '{4'h1, 4'h2, 4'h3, 4'h4};

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic kv, input logic [3:0] code,
                                input logic tl, input logic fp, input logic ov,
                                input logic [2:0] dc, input logic [2:0] fc);
        vec_t v;
        v.rst = rst; v.kv = kv; v.code = code;
        v.tl = tl; v.fp = fp; v.ov = ov; v.dc = dc; v.fc = fc;
        return v;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = exp_q.pop_front();
            check($sformatf("step%0d_toggle_lock", e.idx), toggle_lock, e.tl);
            check($sformatf("step%0d_fail_pulse",  e.idx), fail_pulse,  e.fp);
            check($sformatf("step%0d_override",    e.idx), override,    e.ov);
            check($sformatf("step%0d_digit_count", e.idx), digit_count, e.dc);
            check($sformatf("step%0d_fail_count",  e.idx), fail_count,  e.fc);
            if (toggle_lock && fail_pulse) begin
                checks++;
                failures++;
                $display("FAIL step%0d_exclusive_pulses: got both high expected at most one", e.idx);
            end
        end
    endtask

    // One clock cycle: queue the expectation, drive, clock, compare.
    task automatic apply(input vec_t v);
        exp_t e;
        e.idx = step; e.tl = v.tl; e.fp = v.fp; e.ov = v.ov; e.dc = v.dc; e.fc = v.fc;
        exp_q.push_back(e);
        reset     = v.rst;
        key_valid = v.kv;
        key_code  = v.code;
        @(posedge clk5);
        #1;
        compare_out();
        step++;
    endtask

    task automatic drive(input logic rst, input logic kv, input logic [3:0] code,
                         input logic tl, input logic fp, input logic ov,
                         input logic [2:0] dc, input logic [2:0] fc);
        apply(mk(rst, kv, code, tl, fp, ov, dc, fc));
    endtask

    task automatic add(input logic rst, input logic kv, input logic [3:0] code,
                       input logic tl, input logic fp, input logic ov,
                       input logic [2:0] dc, input logic [2:0] fc);
        table_q.push_back(mk(rst, kv, code, tl, fp, ov, dc, fc));
    endtask

    task automatic run_table();
        foreach (table_q[i]) apply(table_q[i]);
        table_q.delete();
    endtask

    // Correct PIN from IDLE, then one quiet cycle.
    task automatic enter_correct(input logic [2:0] fc_before);
        for (int i = 0; i < 4; i++)
            drive(0, 1, good_pin[i], 0, 0, 0, 3'(i + 1), fc_before);
        drive(0, 1, 4'hF, 1, 0, 0, 0, 0);
        drive(0, 0, 4'h0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (2) @(posedge clk5);
        #1;

        // ---- Table: reset, ignored keys, correct PIN, overflow/short/clear ----
        //   rst kv code  tl fp ov dc fc
        add(1, 0, 4'h0, 0, 0, 0, 0, 0);   // reset state
        add(0, 1, 4'hF, 0, 0, 0, 0, 0);   // enter in IDLE ignored
        add(0, 1, 4'hE, 0, 0, 0, 0, 0);   // clear in IDLE ignored
        add(0, 1, 4'h1, 0, 0, 0, 1, 0);
        add(0, 1, 4'h2, 0, 0, 0, 2, 0);
        add(0, 1, 4'hA, 0, 0, 0, 2, 0);   // A-D ignored in ENTRY
        add(0, 1, 4'h3, 0, 0, 0, 3, 0);
        add(0, 1, 4'h4, 0, 0, 0, 4, 0);
        add(0, 1, 4'hF, 1, 0, 0, 0, 0);   // accepted, 1 cycle after F
        add(0, 0, 4'h0, 0, 0, 0, 0, 0);   // pulse lasts one cycle
        // overflow 1,2,3,4,5
        add(0, 1, 4'h1, 0, 0, 0, 1, 0);
        add(0, 1, 4'h2, 0, 0, 0, 2, 0);
        add(0, 1, 4'h3, 0, 0, 0, 3, 0);
        add(0, 1, 4'h4, 0, 0, 0, 4, 0);
        add(0, 1, 4'h5, 0, 0, 0, 4, 0);   // saturates
        add(0, 1, 4'hF, 0, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 0, 0, 0, 1);
        // short 1,2
        add(0, 1, 4'h1, 0, 0, 0, 1, 1);
        add(0, 1, 4'h2, 0, 0, 0, 2, 1);
        add(0, 1, 4'hF, 0, 1, 0, 0, 2);
        add(0, 0, 4'h0, 0, 0, 0, 0, 2);
        // 1,2,clear then correct PIN resets fail_count
        add(0, 1, 4'h1, 0, 0, 0, 1, 2);
        add(0, 1, 4'h2, 0, 0, 0, 2, 2);
        add(0, 1, 4'hE, 0, 0, 0, 0, 2);
        add(0, 1, 4'h1, 0, 0, 0, 1, 2);
        add(0, 1, 4'h2, 0, 0, 0, 2, 2);
        add(0, 1, 4'h3, 0, 0, 0, 3, 2);
        add(0, 1, 4'h4, 0, 0, 0, 4, 2);
        add(0, 1, 4'hF, 1, 0, 0, 0, 0);
        add(0, 0, 4'h0, 0, 0, 0, 0, 0);
        // one wrong entry after a success: count 1, no block
        add(0, 1, 4'h9, 0, 0, 0, 1, 0);
        add(0, 1, 4'hF, 0, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 0, 0, 0, 1);
        run_table();

        // ---- Timeout: 1,2 then 25 quiet cycles discards the entry ----
        drive(0, 1, 4'h1, 0, 0, 0, 1, 1);
        drive(0, 1, 4'h2, 0, 0, 0, 2, 1);
        for (int k = 1; k <= 24; k++) drive(0, 0, 4'h0, 0, 0, 0, 2, 1);
        drive(0, 0, 4'h0, 0, 0, 0, 0, 1);        // 25th quiet cycle
        drive(0, 1, 4'h3, 0, 0, 0, 1, 1);        // fresh entry from IDLE
        drive(0, 1, 4'h4, 0, 0, 0, 2, 1);
        drive(0, 1, 4'hF, 0, 1, 0, 0, 2);
        drive(0, 0, 4'h0, 0, 0, 0, 0, 2);
        // Key on the expiry cycle wins.
        drive(0, 1, 4'h1, 0, 0, 0, 1, 2);
        drive(0, 1, 4'h2, 0, 0, 0, 2, 2);
        for (int k = 1; k <= 24; k++) drive(0, 0, 4'h0, 0, 0, 0, 2, 2);
        drive(0, 1, 4'h3, 0, 0, 0, 3, 2);
        drive(0, 1, 4'hE, 0, 0, 0, 0, 2);
        enter_correct(3'd2);

        // ---- Three wrong entries: block for exactly 50 cycles ----
        for (int r = 1; r <= 3; r++) begin
            drive(0, 1, 4'h1, 0, 0, 0, 1, 3'(r - 1));
            drive(0, 1, 4'h2, 0, 0, 0, 2, 3'(r - 1));
            drive(0, 1, 4'h3, 0, 0, 0, 3, 3'(r - 1));
            drive(0, 1, 4'h5, 0, 0, 0, 4, 3'(r - 1));
            drive(0, 1, 4'hF, 0, 1, (r == 3), 0, 3'(r));
            if (r < 3) drive(0, 0, 4'h0, 0, 0, 0, 0, 3'(r));
        end
        // The cycle after the last F is block cycle 1, so 49 more high samples follow.
        for (int i = 1; i <= 49; i++) begin
            if (i >= 2 && i <= 5)
                drive(0, 1, good_pin[i - 2], 0, 0, 1, 0, 3);
            else if (i == 6)
                drive(0, 1, 4'hF, 0, 0, 1, 0, 3);
            else
                drive(0, 0, 4'h0, 0, 0, 1, 0, 3);
        end
        drive(0, 0, 4'h0, 0, 0, 0, 0, 0);        // expiry: override low, count cleared
        drive(0, 0, 4'h0, 0, 0, 0, 0, 0);
        enter_correct(3'd0);

        // ---- Reset during block ----
        for (int r = 1; r <= 3; r++) begin
            drive(0, 1, 4'h9, 0, 0, 0, 1, 3'(r - 1));
            drive(0, 1, 4'hF, 0, 1, (r == 3), 0, 3'(r));
            if (r < 3) drive(0, 0, 4'h0, 0, 0, 0, 0, 3'(r));
        end
        for (int i = 1; i <= 9; i++) drive(0, 0, 4'h0, 0, 0, 1, 0, 3);
        drive(1, 1, 4'h1, 0, 0, 0, 0, 0);        // reset beats the key
        enter_correct(3'd0);

        reset     = 1'b0;
        key_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pin_entry_controller.md
Name: pin_entry_controller

Overview:
- Keypad-side controller that collects PIN digits, compares them against a stored code, and drives the door lock FSM.
- Emits a one-cycle toggle_lock pulse on a correct PIN.
- After MAX_FAILS consecutive wrong entries, enters a blocked state and holds override high, so the lock FSM ignores keypad toggles.
- Sits between the debounced keypad scanner and the lock/unlock FSM, in the clk5 domain.

Parameters:
DIGITS, 4, PIN length in digits (1-7)
PIN, 16'h1234, stored code; 4 bits per digit, first-entered digit in most-significant nibble; width 4*DIGITS
MAX_FAILS, 3, consecutive wrong entries that trigger blocking (1-7)
BLOCK_CYCLES, 50, clk5 cycles override stays high
TIMEOUT_CYCLES, 25, clk5 cycles of keypad inactivity that abandon a partial entry

Ports:
clk5  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high; dominates every other input
key_valid  input  1  one-cycle pulse per debounced keypress
key_code  input  4  0-9 = digit, 4'hE = clear, 4'hF = enter; 4'hA-4'hD ignored
toggle_lock  output  1  one-cycle pulse: correct PIN accepted
override  output  1  high while keypad is blocked
fail_pulse  output  1  one-cycle pulse: wrong PIN entered
digit_count  output  3  digits held in buffer, for display (saturates at DIGITS)
fail_count  output  3  consecutive failures since last success or block expiry

Behaviour:
- All outputs are registered.
- Reset values: toggle_lock=0, override=0, fail_pulse=0, digit_count=0, fail_count=0. State=IDLE, buffer cleared, overflow flag=0, timers=0.
- Reset during BLOCKED drops override on the next edge and clears fail_count.
- States: IDLE, ENTRY, BLOCKED.
- Keys are acted on only when key_valid=1.
- IDLE:
  - digit key: load into buffer, digit_count=1, go to ENTRY.
  - clear or enter key: ignored, no fail.
- ENTRY:
  - digit key: shift buffer left 4 bits and insert the digit. digit_count increments, saturating at DIGITS.
  - A digit arriving when digit_count==DIGITS sets the overflow flag.
  - clear key: buffer, digit_count and overflow zeroed; go to IDLE; no fail.
  - enter key, correct entry: correct means digit_count==DIGITS, overflow=0 and buffer==PIN. Next cycle: toggle_lock=1 for exactly one cycle, fail_count=0, go to IDLE.
  - enter key, any other entry: next cycle fail_pulse=1 for one cycle and fail_count increments.
    - If the new fail_count==MAX_FAILS: go to BLOCKED and override=1 in that same cycle.
    - Otherwise: go to IDLE.
  - Buffer, digit_count and overflow are cleared on every enter.
  - Timeout: the inactivity counter restarts on every key_valid. After TIMEOUT_CYCLES consecutive cycles with key_valid=0, the entry is discarded and the FSM goes to IDLE. No fail_pulse; fail_count unchanged.
  - If key_valid arrives in the cycle the timeout would expire, the key wins and is processed.
- BLOCKED:
  - override held high for exactly BLOCK_CYCLES cycles.
  - All keys ignored; they do not extend the block.
  - On expiry: override=0, fail_count=0, go to IDLE.
- toggle_lock and fail_pulse are never high in the same cycle. Neither is asserted while override=1, except the fail_pulse in the entry cycle of BLOCKED.
- Latency from enter sample to toggle_lock or fail_pulse: 1 cycle.
- Counter widths are sized from the parameters, e.g. $clog2(BLOCK_CYCLES+1).

Test Plan:
- Reset, then keys 1,2,3,4,F → toggle_lock high exactly one cycle, 1 cycle after F sampled; fail_count=0; digit_count returns to 0.
- Keys 1,2,3,5,F three times → fail_pulse three times, fail_count 1,2,3. override rises with the third fail_pulse, holds exactly 50 cycles, then fail_count=0. Keys 1,2,3,4,F pressed mid-block produce no toggle_lock.
- Keys 1,2,3,4,5,F (overflow) → fail_pulse. Keys 1,2,F (short) → fail_pulse. Then 1,2,E,1,2,3,4,F → toggle_lock, no fail.
- Keys 1,2, then 25 idle cycles → digit_count=0, no fail_pulse. Then 3,4,F → fail_pulse. Repeat with key 3 exactly on cycle 25 → key accepted, digit_count=3.
- Two wrong entries then correct PIN → toggle_lock and fail_count reset to 0. Next wrong entry → fail_count=1, no block.
- Block triggered, reset asserted 10 cycles in → override=0 and fail_count=0 after the next edge. Keys 1,2,3,4,F then produce toggle_lock.
